// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets one of NUM_REQ requesters at a time burst up
// to MAX_BURST words into a shared FIFO write port.
module fifo_wr_arbiter #(
  parameter int WRITE_WIDTH = 8,
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 4
) (
  input  logic                           wr_clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*WRITE_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             ack,
  input  logic                           full,
  output logic                           wr_en,
  output logic [WRITE_WIDTH-1:0]         din,
  output logic                           busy,
  output logic                           burst_done
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [OW-1:0] LAST_REQ  = OW'(NUM_REQ - 1);
  localparam logic [OW:0]   NUM_REQ_W = (OW+1)'(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_reg, state_next;
  logic [OW-1:0]        owner_reg, owner_next;
  logic [OW-1:0]        last_owner_reg, last_owner_next;
  logic [CW-1:0]        beat_cnt_reg, beat_cnt_next;
  logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
  logic                 burst_done_reg, burst_done_next;
  logic                 armed_reg;

  logic [WRITE_WIDTH-1:0] slice [NUM_REQ];
  logic [NUM_REQ-1:0]     owner_onehot;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic                   owner_req;

  logic [OW-1:0]          start_idx;
  logic [2*NUM_REQ-1:0]   req_dbl;
  logic [2*NUM_REQ-1:0]   req_shift;
  logic [NUM_REQ-1:0]     req_rot;
  logic [OW-1:0]          pick_off;
  logic [OW:0]            pick_sum;
  logic [OW-1:0]          pick;
  logic                   pick_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign slice[gi]        = req_data[gi*WRITE_WIDTH +: WRITE_WIDTH];
      assign owner_onehot[gi] = (owner_reg == OW'(gi));
      assign pick_onehot[gi]  = (pick == OW'(gi));
    end
  endgenerate

  // Rotate req so that bit 0 is the requester just after last_owner; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  assign start_idx = (last_owner_reg == LAST_REQ) ? '0 : last_owner_reg + 1'b1;
  assign req_dbl   = {req, req};
  assign req_shift = req_dbl >> start_idx;
  assign req_rot   = req_shift[NUM_REQ-1:0];

  always_comb begin
    pick_valid = |req;
    pick_off   = '0;
    for (int p = NUM_REQ - 1; p >= 0; p--) begin
      if (req_rot[p]) pick_off = OW'(p);
    end
    pick_sum = {1'b0, start_idx} + {1'b0, pick_off};
    if (pick_sum >= NUM_REQ_W) pick = OW'(pick_sum - NUM_REQ_W);
    else                       pick = pick_sum[OW-1:0];
  end

  assign owner_req = |(req & owner_onehot);
  assign wr_en     = (state_reg == GRANT) && owner_req && !full;
  assign ack       = wr_en ? owner_onehot : '0;
  assign busy      = (state_reg == GRANT);
  assign gnt       = gnt_reg;
  assign burst_done = burst_done_reg;

  always_comb begin
    din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_reg == GRANT) && owner_onehot[i]) din = slice[i];
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    beat_cnt_next   = beat_cnt_reg;
    gnt_next        = gnt_reg;
    burst_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        gnt_next = '0;
        if (armed_reg && pick_valid) begin
          state_next      = GRANT;
          owner_next      = pick;
          last_owner_next = pick;
          beat_cnt_next   = '0;
          gnt_next        = pick_onehot;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_next      = IDLE;
          gnt_next        = '0;
          burst_done_next = 1'b1;
        end else if (wr_en) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
          if (beat_cnt_reg == LAST_BEAT) begin
            state_next      = IDLE;
            gnt_next        = '0;
            burst_done_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // armed_reg holds off arbitration for the first edge after reset release.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_owner_reg <= LAST_REQ;
      beat_cnt_reg   <= '0;
      gnt_reg        <= '0;
      burst_done_reg <= 1'b0;
      armed_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      beat_cnt_reg   <= beat_cnt_next;
      gnt_reg        <= gnt_next;
      burst_done_reg <= burst_done_next;
      armed_reg      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter against a grant/burst
// level reference model with a per-requester write scoreboard.
module tb_fifo_wr_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic             wr_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   req_data = '0;
  logic             full = 1'b0;
  logic [N-1:0]     gnt, ack;
  logic             wr_en;
  logic [W-1:0]     din;
  logic             busy, burst_done;

  fifo_wr_arbiter #(.WRITE_WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .ack(ack), .full(full), .wr_en(wr_en), .din(din),
    .busy(busy), .burst_done(burst_done)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, how many words this grant has
  // written, and the next word index each requester is presenting.
  int seq [N];
  int m_owner, m_last, m_writes;
  bit m_done, m_armed;
  int grant_log[$];
  int burst_log[$];
  logic [W-1:0] write_log[$];

  function automatic logic [W-1:0] word_of(int r, int n);
    return W'(r * 64 + (n % 63) + 1);
  endfunction

  function automatic bit req_bit(int r);
    return ((req >> r) & 1) != 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_last   = N - 1;
    m_writes = 0;
    m_done   = 0;
    m_armed  = 0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    grant_log.delete();
    burst_log.delete();
    write_log.delete();
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = word_of(i, seq[i]);
  endtask

  // One clock cycle: inputs are set at the falling edge, outputs checked
  // 1 time unit later, model advanced at the rising edge.
  task automatic cycle();
    logic         exp_wr;
    logic [N-1:0] exp_gnt, exp_ack;
    logic [W-1:0] exp_din;
    int           pick;
    drive_data();
    #1;
    if (!rst_n) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_burst_done", burst_done, 0);
      @(negedge wr_clk);
      return;
    end
    exp_wr  = (m_owner >= 0) && req_bit(m_owner) && !full;
    exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    exp_ack = exp_wr ? exp_gnt : '0;
    exp_din = (m_owner >= 0) ? word_of(m_owner, seq[m_owner]) : '0;
    chk("gnt", gnt, exp_gnt);
    chk("busy", busy, m_owner >= 0);
    chk("wr_en", wr_en, exp_wr);
    chk("ack", ack, exp_ack);
    chk("din", din, exp_din);
    chk("burst_done", burst_done, m_done);
    chk("wr_while_full", wr_en & full, 0);
    if (wr_en) write_log.push_back(din);
    @(posedge wr_clk);
    m_done = 0;
    if (m_owner < 0) begin
      if (!m_armed) m_armed = 1;
      else if (req != '0) begin
        pick = -1;
        for (int k = 1; k <= N; k++) begin
          if (pick < 0 && req_bit((m_last + k) % N)) pick = (m_last + k) % N;
        end
        m_owner  = pick;
        m_last   = pick;
        m_writes = 0;
        grant_log.push_back(pick);
      end
    end else if (!req_bit(m_owner)) begin
      burst_log.push_back(m_writes);
      m_owner = -1;
      m_done  = 1;
    end else if (exp_wr) begin
      seq[m_owner]++;
      m_writes++;
      if (m_writes == MB) begin
        burst_log.push_back(m_writes);
        m_owner = -1;
        m_done  = 1;
      end
    end
    @(negedge wr_clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    model_reset();
    @(negedge wr_clk);

    // Single requester: 4-word burst, bubble, regrant
    apply_reset();
    cycle();
    cycle();
    req = 4'b0001;
    cycle();
    chk("t1_gnt_after_1", gnt, 4'b0001);
    for (int c = 0; c < 11; c++) cycle();
    for (int i = 0; i < 5; i++) chk($sformatf("t1_word%0d", i), write_log[i], i + 1);
    chk("t1_first_burst", burst_log[0], 4);

    // All requesting: rotation 0,1,2,3,0 with full bursts
    req = '0;
    apply_reset();
    req = 4'b1111;
    for (int c = 0; c < 30; c++) cycle();
    for (int i = 0; i < 5; i++) chk($sformatf("t2_grant%0d", i), grant_log[i], i % 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_burst%0d", i), burst_log[i], 4);

    // Owner 2 stalled by full mid-burst
    req = '0;
    apply_reset();
    req = 4'b0100;
    n = 0;
    while (m_writes < 1 && n < 20) begin cycle(); n++; end
    if (n >= 20) timeout_fail("t3_first_write");
    full = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    full = 1'b0;
    n = 0;
    while (burst_log.size() < 1 && n < 20) begin cycle(); n++; end
    if (n >= 20) timeout_fail("t3_burst_end");
    chk("t3_burst_len", burst_log[0], 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_word%0d", i), write_log[i], word_of(2, i));

    // Owner 1 releases after 2 writes, requester 3 pending
    req = '0;
    apply_reset();
    req = 4'b0010;
    n = 0;
    while (m_owner != 1 && n < 20) begin cycle(); n++; end
    if (n >= 20) timeout_fail("t4_grant1");
    req = 4'b1010;
    n = 0;
    while (m_writes < 2 && n < 20) begin cycle(); n++; end
    if (n >= 20) timeout_fail("t4_two_writes");
    req = 4'b1000;
    cycle();
    chk("t4_done_pulse", burst_done, 1);
    n = 0;
    while (grant_log.size() < 2 && n < 20) begin cycle(); n++; end
    if (n >= 20) timeout_fail("t4_regrant");
    chk("t4_burst_len", burst_log[0], 2);
    chk("t4_next_owner", grant_log[1], 3);
    chk("t4_next_gnt", gnt, 4'b1000);

    // Reset asserted during beat 3
    req = '0;
    apply_reset();
    req = 4'b1111;
    n = 0;
    while (m_writes < 2 && n < 20) begin cycle(); n++; end
    if (n >= 20) timeout_fail("t5_beat3");
    drive_data();
    #1;
    chk("t5_pre_rst_wr_en", wr_en, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_wr_en", wr_en, 0);
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_ack", ack, 0);
    @(negedge wr_clk);
    model_reset();
    cycle();
    req = 4'b0110;
    rst_n = 1'b1;
    cycle();
    chk("t5_no_early_gnt", gnt, 0);
    for (int c = 0; c < 3; c++) cycle();
    chk("t5_first_owner", grant_log[0], 1);

    // Randomized traffic with back-pressure and one mid-run reset
    req = '0;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      full = ($urandom_range(0, 3) == 0);
      if (c == 400) apply_reset();
      cycle();
    end
    full = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter WRITE_WIDTH, default 8, the FIFO write data width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4, the number of requesters; legal range 2..16.
REQ-003 SHALL have parameter MAX_BURST, default 4, the maximum words per grant; legal range 1..256.
REQ-004 SHALL have port wr_clk, input, 1, the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req, input, NUM_REQ, where req[i] high means requester i has a valid word on its data slice.
REQ-007 SHALL have port req_data, input, NUM_REQ*WRITE_WIDTH, where slice i is bits [i*WRITE_WIDTH +: WRITE_WIDTH].
REQ-008 SHALL have port gnt, output, NUM_REQ, a registered one-hot indicator of the current owner.
REQ-009 SHALL have port ack, output, NUM_REQ, where ack[i] is a one-cycle pulse meaning the word of requester i was written this cycle.
REQ-010 SHALL have port full, input, 1, the FIFO full flag, write-clock domain.
REQ-011 SHALL have port wr_en, output, 1, the FIFO write enable.
REQ-012 SHALL have port din, output, WRITE_WIDTH, the FIFO write data.
REQ-013 SHALL have port busy, output, 1, high while in state GRANT.
REQ-014 SHALL have port burst_done, output, 1, a one-cycle registered pulse on the cycle after the owner releases.

Function
REQ-015 SHALL implement two states: IDLE and GRANT.
REQ-016 In IDLE with any req bit high, SHALL pick the owner by round-robin search from last_owner+1 upward, modulo NUM_REQ.
- Also in that case, SHALL enter GRANT on the next edge, setting gnt, owner, last_owner=owner and beat_cnt=0.
- Arbitration latency is one cycle, from req to gnt.
REQ-017 In IDLE with req all zero, SHALL remain in IDLE with gnt=0.
REQ-018 SHALL drive wr_en combinationally as (state==GRANT) && req[owner] && !full.
REQ-019 SHALL drive din as req_data slice owner while in GRANT, and 0 otherwise.
REQ-020 SHALL assert ack[owner]=wr_en, with all other ack bits 0; a requester advances its data only on ack.
REQ-021 In GRANT, each cycle with wr_en=1 SHALL increment beat_cnt, a $clog2(MAX_BURST)+1-bit counter.
REQ-022 In GRANT, a cycle with full=1 SHALL stall: no write, no count, owner retained.
REQ-023 In GRANT, SHALL return to IDLE when wr_en=1 and beat_cnt==MAX_BURST-1 (burst limit reached).
REQ-024 In GRANT, SHALL return to IDLE when req[owner]=0 (owner release), with no write in that cycle.
REQ-025 On either exit from GRANT, SHALL clear gnt at the edge and pulse burst_done for one cycle.
- One IDLE bubble cycle always separates consecutive grants.
REQ-026 With MAX_BURST=1, every write SHALL end the grant.
REQ-027 Round-robin SHALL wrap from owner NUM_REQ-1 to owner 0.
- A requester that has just released SHALL have the lowest priority at the next arbitration.
REQ-028 When req changes in IDLE, SHALL sample only at the arbitration edge; no glitching of gnt.
REQ-029 SHALL never assert wr_en while full=1, and never assert more than one ack bit.

Reset
REQ-030 While rst_n=0, asynchronously: state=IDLE, gnt=0, beat_cnt=0, burst_done=0, last_owner=NUM_REQ-1.
- Consequently, requester 0 wins the first arbitration.
REQ-031 Reset mid-burst SHALL drop wr_en and ack to 0 in the same cycle; the burst is discarded with no partial state.
REQ-032 After rst_n rises, the first grant SHALL occur no earlier than the second rising edge of wr_clk.

Verification
REQ-033 req=4'b0001 held, data 1,2,3,4,5, full=0, MAX_BURST=4:
- gnt=0001 after 1 cycle;
- wr_en high 4 cycles, din 1..4;
- burst_done pulse, 1 bubble, then a regrant writes 5.
REQ-034 req=4'b1111 held continuously:
- grants in order 0,1,2,3,0;
- each grant yields exactly 4 acks to its owner.
REQ-035 Owner 2 granted, full=1 for 3 cycles mid-burst:
- wr_en=0 and beat_cnt frozen during the stall;
- burst completes with 4 total writes, no word lost or duplicated.
REQ-036 Owner 1 drops req after 2 writes, req[3] pending:
- grant ends with 2 acks and burst_done pulses;
- next gnt=1000.
REQ-037 rst_n pulled low during beat 3 of a burst:
- wr_en, gnt and ack are 0 immediately;
- after release with req=4'b0110, the first grant goes to requester 1.
REQ-038 A scoreboard SHALL check throughout every test:
- FIFO write order equals the per-requester ack order;
- no wr_en while full.
